api_extension_mux: RTL and testbench

Parametrised successor to the single-level API extension bridge. It takes the baseline I/O port (command/status/address/data) from network_path_shared and decodes the top address byte to one of NUM_EXT extension channels or to an internal register bank. It adds the following, which the previous generation lacked:
- configurable channel count and prefixes
- configurable wait cycles
- error counting and latching of the last failing address
- an optional access watchdog

---
 rtl/api_extension_pkg.sv | 42 ++++
 rtl/api_extension_decoder.sv | 32 +++
 rtl/api_extension_mux.sv | 204 ++++++++++++++++++++
 tb/tb_api_extension_mux.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/api_extension_pkg.sv
// Shared codes for the API extension mux: command/status encodings, FSM states,
// internal register map and identification constants.
package api_extension_pkg;

   typedef enum logic [1:0] {
      CMD_IDLE    = 2'd0,
      CMD_READ    = 2'd1,
      CMD_ILLEGAL = 2'd2,
      CMD_WRITE   = 2'd3
   } command_e;

   typedef enum logic [1:0] {
      STAT_BUSY  = 2'd0,
      STAT_READY = 2'd1,
      STAT_ERROR = 2'd3
   } status_e;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_ACCESS = 2'd2,
      S_DONE   = 2'd3
   } state_e;

   localparam logic [7:0] INT_PREFIX   = 8'h00;

   localparam logic [7:0] REG_NAME0    = 8'h00;
   localparam logic [7:0] REG_NAME1    = 8'h01;
   localparam logic [7:0] REG_VERSION  = 8'h02;
   localparam logic [7:0] REG_NUM_EXT  = 8'h03;
   localparam logic [7:0] REG_OP_A     = 8'h10;
   localparam logic [7:0] REG_OP_B     = 8'h11;
   localparam logic [7:0] REG_SUM      = 8'h12;
   localparam logic [7:0] REG_ERR_CNT  = 8'h20;
   localparam logic [7:0] REG_ERR_ADDR = 8'h21;

   localparam logic [31:0] NAME0         = 32'h6170692d;  // "api-"
   localparam logic [31:0] NAME1         = 32'h65787420;  // "ext "
   localparam logic [31:0] VERSION       = 32'h302e3230;  // "0.20"
   localparam logic [31:0] TIMEOUT_RDATA = 32'hdeaddead;

endpackage

// File: rtl/api_extension_decoder.sv
// Prefix decoder: maps an address prefix to the internal bank, the lowest matching
// extension channel (one-hot), or a miss. Purely combinational.
module api_extension_decoder
   import api_extension_pkg::*;
#(
   parameter int                   NUM_EXT      = 4,
   parameter logic [NUM_EXT*8-1:0] EXT_PREFIXES = {8'hfe, 8'h12, 8'h11, 8'h10}
) (
   input  logic [7:0]         prefix,
   output logic [NUM_EXT-1:0] sel,
   output logic               int_hit,
   output logic               miss
);

   always_comb begin
      sel     = '0;
      int_hit = (prefix == INT_PREFIX);
      miss    = 1'b0;
      if (!int_hit) begin
         // Descending scan so the lowest matching index is the one that sticks;
         // a zero table entry is unused and can never match.
         for (int i = NUM_EXT - 1; i >= 0; i--) begin
            if (EXT_PREFIXES[8*i +: 8] != INT_PREFIX && EXT_PREFIXES[8*i +: 8] == prefix) begin
               sel    = '0;
               sel[i] = 1'b1;
            end
         end
         miss = (sel == '0);
      end
   end

endmodule

// File: rtl/api_extension_mux.sv
// Command/status bridge decoding address[31:24] to NUM_EXT extension channels or an internal bank.
// Access takes WAIT_CYCLES+3 cycles from command sample when the target is ready; API_EXT_TIMEOUT_EN adds an ACCESS watchdog.
module api_extension_mux
   import api_extension_pkg::*;
#(
   parameter int                   NUM_EXT        = 4,
   parameter int                   EXT_ADDR_WIDTH = 24,
   parameter int                   WAIT_CYCLES    = 2,
   parameter logic [NUM_EXT*8-1:0] EXT_PREFIXES   = {8'hfe, 8'h12, 8'h11, 8'h10},
   parameter int                   TIMEOUT_CYCLES = 255
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [1:0]                command,
   output logic [1:0]                status,
   input  logic [31:0]               address,
   input  logic [31:0]               write_data,
   output logic [31:0]               read_data,
   output logic [NUM_EXT-1:0]        ext_cs,
   output logic [NUM_EXT-1:0]        ext_we,
   output logic [EXT_ADDR_WIDTH-1:0] ext_address,
   output logic [31:0]               ext_write_data,
   input  logic [32*NUM_EXT-1:0]     ext_read_data,
   input  logic [NUM_EXT-1:0]        ext_ready
);

   if (NUM_EXT < 1 || NUM_EXT > 16 || EXT_ADDR_WIDTH < 8 || EXT_ADDR_WIDTH > 24 ||
       WAIT_CYCLES < 0 || WAIT_CYCLES > 15 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
      $error("api_extension_mux: parameter out of range");
   end

   localparam logic [3:0] WAIT_LIMIT = 4'(WAIT_CYCLES);

   state_e        state, state_nxt;
   status_e       status_reg;
   logic [1:0]    command_reg;
   logic [31:0]   address_reg;
   logic [31:0]   write_data_reg;
   logic          we_reg;
   logic          cs_reg;
   logic          illegal_reg;
   logic          ready_reg;
   logic [3:0]    wait_ctr;
   logic [31:0]   op_a, op_b, sum_reg;
   logic [31:0]   err_cnt, err_addr;

   logic [NUM_EXT-1:0] sel;
   logic               int_hit, miss;
   logic               tgt_ready;
   logic [31:0]        ext_rdata, int_rdata, sel_rdata;
   logic               start, complete, timeout;
   logic               err_evt, err_clr, int_wr;

   api_extension_decoder #(
      .NUM_EXT      (NUM_EXT),
      .EXT_PREFIXES (EXT_PREFIXES)
   ) u_decoder (
      .prefix  (address_reg[31:24]),
      .sel     (sel),
      .int_hit (int_hit),
      .miss    (miss)
   );

   assign status         = status_reg;
   assign ext_cs         = cs_reg ? sel : '0;
   assign ext_we         = (cs_reg && we_reg) ? sel : '0;
   assign ext_address    = address_reg[EXT_ADDR_WIDTH-1:0];
   assign ext_write_data = write_data_reg;

   // Internal bank and unmapped prefixes answer immediately.
   assign tgt_ready = int_hit | miss | (|(sel & ext_ready));

   always_comb begin
      ext_rdata = '0;
      for (int i = 0; i < NUM_EXT; i++) begin
         if (sel[i]) ext_rdata = ext_read_data[32*i +: 32];
      end
   end

   always_comb begin
      int_rdata = '0;
      case (address_reg[7:0])
         REG_NAME0:    int_rdata = NAME0;
         REG_NAME1:    int_rdata = NAME1;
         REG_VERSION:  int_rdata = VERSION;
         REG_NUM_EXT:  int_rdata = 32'(NUM_EXT);
         REG_OP_A:     int_rdata = op_a;
         REG_OP_B:     int_rdata = op_b;
         REG_SUM:      int_rdata = sum_reg;
         REG_ERR_CNT:  int_rdata = err_cnt;
         REG_ERR_ADDR: int_rdata = err_addr;
         default:      int_rdata = '0;
      endcase
   end

   assign sel_rdata = int_hit ? int_rdata : ext_rdata;

`ifdef API_EXT_TIMEOUT_EN
   localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] to_ctr;

   always_ff @(posedge clk) begin
      if (reset) begin
         to_ctr <= '0;
      end else if (state != S_ACCESS) begin
         to_ctr <= '0;
      end else begin
         to_ctr <= to_ctr + 16'd1;
      end
   end

   // Ready on the limit cycle still wins over the watchdog.
   assign timeout = (state == S_ACCESS) && !ready_reg && (to_ctr == TO_LIMIT);
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:   if (command_reg != CMD_IDLE) state_nxt = S_WAIT;
         S_WAIT:   if (wait_ctr == WAIT_LIMIT) state_nxt = S_ACCESS;
         S_ACCESS: if (ready_reg || timeout) state_nxt = S_DONE;
         S_DONE:   if (command_reg == CMD_IDLE) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   assign start    = (state == S_IDLE) && (command_reg != CMD_IDLE);
   assign complete = (state == S_ACCESS) && ready_reg;
   assign int_wr   = complete && we_reg && int_hit;
   assign err_evt  = (complete && (miss || illegal_reg)) || timeout;
   assign err_clr  = int_wr && (address_reg[7:0] == REG_ERR_CNT);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         status_reg     <= STAT_READY;
         read_data      <= '0;
         command_reg    <= '0;
         address_reg    <= '0;
         write_data_reg <= '0;
         we_reg         <= 1'b0;
         cs_reg         <= 1'b0;
         illegal_reg    <= 1'b0;
         ready_reg      <= 1'b0;
         wait_ctr       <= '0;
         op_a           <= '0;
         op_b           <= '0;
         sum_reg        <= '0;
         err_cnt        <= '0;
         err_addr       <= '0;
      end else begin
         command_reg <= command;
         ready_reg   <= tgt_ready;
         sum_reg     <= op_a + op_b;

         if (start) begin
            address_reg    <= address;
            write_data_reg <= write_data;
            we_reg         <= (command_reg == CMD_WRITE);
            cs_reg         <= (command_reg != CMD_ILLEGAL);
            illegal_reg    <= (command_reg == CMD_ILLEGAL);
            status_reg     <= STAT_BUSY;
            wait_ctr       <= '0;
         end

         if (state == S_WAIT) wait_ctr <= wait_ctr + 4'd1;

         if (complete) begin
            read_data  <= (we_reg || illegal_reg) ? 32'd0 : sel_rdata;
            status_reg <= (miss || illegal_reg) ? STAT_ERROR : STAT_READY;
            cs_reg     <= 1'b0;
            we_reg     <= 1'b0;
         end else if (timeout) begin
            read_data  <= TIMEOUT_RDATA;
            status_reg <= STAT_ERROR;
            cs_reg     <= 1'b0;
            we_reg     <= 1'b0;
         end

         if (state == S_DONE && command_reg == CMD_IDLE) status_reg <= STAT_READY;

         if (int_wr && address_reg[7:0] == REG_OP_A) op_a <= write_data_reg;
         if (int_wr && address_reg[7:0] == REG_OP_B) op_b <= write_data_reg;

         // A clear beats a concurrent error increment.
         if (err_clr) begin
            err_cnt <= '0;
         end else if (err_evt && err_cnt != 32'hffffffff) begin
            err_cnt <= err_cnt + 32'd1;
         end
         if (err_evt) err_addr <= address_reg;
      end
   end

endmodule

// File: tb/tb_api_extension_mux.sv
// Self-checking bench for api_extension_mux: scenario tasks push expected results into a
// scoreboard queue at issue time and compare against the DUT's completed accesses.
module tb_api_extension_mux;
   import api_extension_pkg::*;

   localparam int NUM_EXT        = 4;
   localparam int WAIT_CYCLES    = 2;
   localparam int TIMEOUT_CYCLES = 8;

   logic                   clk = 1'b0;
   logic                   reset;
   logic [1:0]             command;
   logic [1:0]             status;
   logic [31:0]            address;
   logic [31:0]            write_data;
   logic [31:0]            read_data;
   logic [NUM_EXT-1:0]     ext_cs;
   logic [NUM_EXT-1:0]     ext_we;
   logic [23:0]            ext_address;
   logic [31:0]            ext_write_data;
   logic [32*NUM_EXT-1:0]  ext_read_data;
   logic [NUM_EXT-1:0]     ext_ready;

   int checks = 0;
   int errors = 0;

   logic [1:0]  exp_status_q[$];
   logic [31:0] exp_data_q[$];
   logic [1:0]  obs_status_q[$];
   logic [31:0] obs_data_q[$];
   string       name_q[$];

   logic [NUM_EXT-1:0] cs_seen;
   int                 last_lat;

   api_extension_mux #(
      .NUM_EXT        (NUM_EXT),
      .EXT_ADDR_WIDTH (24),
      .WAIT_CYCLES    (WAIT_CYCLES),
      .EXT_PREFIXES   ({8'hfe, 8'h12, 8'h11, 8'h10}),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .command        (command),
      .status         (status),
      .address        (address),
      .write_data     (write_data),
      .read_data      (read_data),
      .ext_cs         (ext_cs),
      .ext_we         (ext_we),
      .ext_address    (ext_address),
      .ext_write_data (ext_write_data),
      .ext_read_data  (ext_read_data),
      .ext_ready      (ext_ready)
   );

   always #5 clk = ~clk;

   task automatic drive_cmd(input logic [1:0] cmd, input logic [31:0] addr, input logic [31:0] wd);
      @(negedge clk);
      command    = cmd;
      address    = addr;
      write_data = wd;
   endtask

   task automatic release_cmd();
      @(negedge clk);
      command = CMD_IDLE;
      repeat (2) @(negedge clk);
   endtask

   // Waits (bounded) for BUSY then for completion; last_lat counts edges from the sampling edge.
   task automatic wait_done(input string name);
      int n = 0;
      bit busy_seen = 1'b0;
      bit done = 1'b0;
      cs_seen = '0;
      while (!done && n < 200) begin
         @(posedge clk);
         #1;
         n++;
         cs_seen |= ext_cs;
         if (status === STAT_BUSY) busy_seen = 1'b1;
         else if (busy_seen) done = 1'b1;
      end
      last_lat = n;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s completion: status=%0d after %0d cycles, required completion", name, status, n);
      end
   endtask

   task automatic capture(input string name);
      obs_status_q.push_back(status);
      obs_data_q.push_back(read_data);
      name_q.push_back(name);
   endtask

   task automatic issue(input logic [1:0] cmd, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [1:0] es, input logic [31:0] ed, input string name);
      exp_status_q.push_back(es);
      exp_data_q.push_back(ed);
      drive_cmd(cmd, addr, wd);
      wait_done(name);
      capture(name);
      release_cmd();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (status !== STAT_READY) begin errors++; $display("FAIL reset_status: got %0d required %0d", status, STAT_READY); end
      checks++;
      if (read_data !== 32'd0) begin errors++; $display("FAIL reset_read_data: got %h required 0", read_data); end
      checks++;
      if (ext_cs !== 4'b0000 || ext_we !== 4'b0000) begin
         errors++; $display("FAIL reset_cs_we: got cs=%b we=%b required 0000", ext_cs, ext_we);
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_internal_bank();
      issue(CMD_READ, 32'h00000002, 32'd0, STAT_READY, 32'h302e3230, "version");
      checks++;
      if (last_lat - 1 !== WAIT_CYCLES + 3) begin
         errors++; $display("FAIL version_latency: got %0d required %0d", last_lat - 1, WAIT_CYCLES + 3);
      end
      issue(CMD_READ,  32'h00000000, 32'd0,        STAT_READY, 32'h6170692d, "name0");
      issue(CMD_READ,  32'h00000001, 32'd0,        STAT_READY, 32'h65787420, "name1");
      issue(CMD_READ,  32'h00000003, 32'd0,        STAT_READY, 32'd4,        "num_ext");
      issue(CMD_WRITE, 32'h00000010, 32'd5,        STAT_READY, 32'd0,        "wr_op_a");
      issue(CMD_WRITE, 32'h00000011, 32'd7,        STAT_READY, 32'd0,        "wr_op_b");
      issue(CMD_READ,  32'h00000012, 32'd0,        STAT_READY, 32'h0000000c, "sum");
      issue(CMD_READ,  32'h00000010, 32'd0,        STAT_READY, 32'd5,        "rd_op_a");
      issue(CMD_WRITE, 32'h00000010, 32'hffffffff, STAT_READY, 32'd0,        "wr_op_a_max");
      issue(CMD_WRITE, 32'h00000011, 32'd1,        STAT_READY, 32'd0,        "wr_op_b_one");
      issue(CMD_READ,  32'h00000012, 32'd0,        STAT_READY, 32'd0,        "sum_wrap");
      issue(CMD_READ,  32'h00000030, 32'd0,        STAT_READY, 32'd0,        "unmapped");
      while (exp_status_q.size() > 0) begin
         logic [1:0] es, os; logic [31:0] ed, od; string nm;
         es = exp_status_q.pop_front(); ed = exp_data_q.pop_front();
         os = obs_status_q.pop_front(); od = obs_data_q.pop_front(); nm = name_q.pop_front();
         checks++;
         if (os !== es) begin errors++; $display("FAIL %s status: got %0d required %0d", nm, os, es); end
         checks++;
         if (od !== ed) begin errors++; $display("FAIL %s data: got %h required %h", nm, od, ed); end
      end
   endtask

   task automatic test_ext_write();
      bit stall_ok = 1'b1;
      ext_ready = 4'b1101;
      exp_status_q.push_back(STAT_READY);
      exp_data_q.push_back(32'd0);
      drive_cmd(CMD_WRITE, 32'h11000abc, 32'hcafe0001);
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (ext_cs !== 4'b0010 || ext_we !== 4'b0010) begin
         errors++; $display("FAIL ext_wr_select: got cs=%b we=%b required 0010/0010", ext_cs, ext_we);
      end
      checks++;
      if (ext_address !== 24'h000abc || ext_write_data !== 32'hcafe0001) begin
         errors++; $display("FAIL ext_wr_bus: got addr=%h data=%h required 000abc/cafe0001", ext_address, ext_write_data);
      end
      repeat (10) begin
         @(posedge clk);
         #1;
         if (status !== STAT_BUSY || ext_cs !== 4'b0010) stall_ok = 1'b0;
      end
      checks++;
      if (!stall_ok) begin errors++; $display("FAIL ext_wr_stall: got status=%0d cs=%b required BUSY/0010", status, ext_cs); end
      @(negedge clk);
      ext_ready = 4'b1111;
      wait_done("ext_write");
      capture("ext_write");
      checks++;
      if (ext_cs !== 4'b0000) begin errors++; $display("FAIL ext_wr_cs_drop: got %b required 0000", ext_cs); end
      release_cmd();
      while (exp_status_q.size() > 0) begin
         logic [1:0] es, os; logic [31:0] ed, od; string nm;
         es = exp_status_q.pop_front(); ed = exp_data_q.pop_front();
         os = obs_status_q.pop_front(); od = obs_data_q.pop_front(); nm = name_q.pop_front();
         checks++;
         if (os !== es) begin errors++; $display("FAIL %s status: got %0d required %0d", nm, os, es); end
         checks++;
         if (od !== ed) begin errors++; $display("FAIL %s data: got %h required %h", nm, od, ed); end
      end
   endtask

   task automatic test_ext_read();
      ext_ready = 4'b1111;
      issue(CMD_READ, 32'h12000040, 32'd0, STAT_READY, 32'h12345678, "ext_rd_ch2");
      checks++;
      if (cs_seen !== 4'b0100) begin errors++; $display("FAIL ext_rd_ch2_cs: got %b required 0100", cs_seen); end
      issue(CMD_READ, 32'h10000000, 32'd0, STAT_READY, 32'h00001000, "ext_rd_ch0");
      while (exp_status_q.size() > 0) begin
         logic [1:0] es, os; logic [31:0] ed, od; string nm;
         es = exp_status_q.pop_front(); ed = exp_data_q.pop_front();
         os = obs_status_q.pop_front(); od = obs_data_q.pop_front(); nm = name_q.pop_front();
         checks++;
         if (os !== es) begin errors++; $display("FAIL %s status: got %0d required %0d", nm, os, es); end
         checks++;
         if (od !== ed) begin errors++; $display("FAIL %s data: got %h required %h", nm, od, ed); end
      end
   endtask

   task automatic test_errors();
      issue(CMD_READ, 32'h55000000, 32'd0, STAT_ERROR, 32'd0, "miss_read");
      checks++;
      if (cs_seen !== 4'b0000) begin errors++; $display("FAIL miss_no_cs: got %b required 0000", cs_seen); end
      checks++;
      if (status !== STAT_READY) begin errors++; $display("FAIL miss_back_ready: got %0d required %0d", status, STAT_READY); end
      issue(CMD_READ,    32'h00000020, 32'd0, STAT_READY, 32'd1,        "err_cnt_1");
      issue(CMD_READ,    32'h00000021, 32'd0, STAT_READY, 32'h55000000, "err_addr_1");
      issue(CMD_WRITE,   32'h00000020, 32'h0000abcd, STAT_READY, 32'd0, "err_cnt_clr");
      issue(CMD_READ,    32'h00000020, 32'd0, STAT_READY, 32'd0,        "err_cnt_0");
      issue(CMD_ILLEGAL, 32'h00000003, 32'd0, STAT_ERROR, 32'd0,        "illegal_cmd");
      issue(CMD_READ,    32'h00000020, 32'd0, STAT_READY, 32'd1,        "err_cnt_ill");
      issue(CMD_READ,    32'h00000021, 32'd0, STAT_READY, 32'h00000003, "err_addr_ill");
      while (exp_status_q.size() > 0) begin
         logic [1:0] es, os; logic [31:0] ed, od; string nm;
         es = exp_status_q.pop_front(); ed = exp_data_q.pop_front();
         os = obs_status_q.pop_front(); od = obs_data_q.pop_front(); nm = name_q.pop_front();
         checks++;
         if (os !== es) begin errors++; $display("FAIL %s status: got %0d required %0d", nm, os, es); end
         checks++;
         if (od !== ed) begin errors++; $display("FAIL %s data: got %h required %h", nm, od, ed); end
      end
   endtask

   task automatic test_timeout();
      ext_ready = 4'b0111;
`ifdef API_EXT_TIMEOUT_EN
      issue(CMD_READ, 32'hfe000004, 32'd0, STAT_ERROR, 32'hdeaddead, "timeout");
      checks++;
      if (last_lat - 1 !== WAIT_CYCLES + 2 + TIMEOUT_CYCLES) begin
         errors++; $display("FAIL timeout_latency: got %0d required %0d", last_lat - 1, WAIT_CYCLES + 2 + TIMEOUT_CYCLES);
      end
      ext_ready = 4'b1111;
      issue(CMD_READ, 32'h00000020, 32'd0, STAT_READY, 32'd2,        "err_cnt_to");
      issue(CMD_READ, 32'h00000021, 32'd0, STAT_READY, 32'hfe000004, "err_addr_to");
`else
      begin
         bit hold_ok = 1'b1;
         exp_status_q.push_back(STAT_READY);
         exp_data_q.push_back(32'hfeedface);
         drive_cmd(CMD_READ, 32'hfe000004, 32'd0);
         repeat (2) @(posedge clk);
         repeat (40) begin
            @(posedge clk);
            #1;
            if (status !== STAT_BUSY) hold_ok = 1'b0;
         end
         checks++;
         if (!hold_ok) begin errors++; $display("FAIL no_watchdog_hold: got status=%0d required BUSY", status); end
         @(negedge clk);
         ext_ready = 4'b1111;
         wait_done("late_ready");
         capture("late_ready");
         release_cmd();
      end
`endif
      while (exp_status_q.size() > 0) begin
         logic [1:0] es, os; logic [31:0] ed, od; string nm;
         es = exp_status_q.pop_front(); ed = exp_data_q.pop_front();
         os = obs_status_q.pop_front(); od = obs_data_q.pop_front(); nm = name_q.pop_front();
         checks++;
         if (os !== es) begin errors++; $display("FAIL %s status: got %0d required %0d", nm, os, es); end
         checks++;
         if (od !== ed) begin errors++; $display("FAIL %s data: got %h required %h", nm, od, ed); end
      end
      ext_ready = 4'b1111;
   endtask

   task automatic test_reset_mid_access();
      ext_ready = 4'b1111;
      drive_cmd(CMD_READ, 32'h10000000, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (ext_cs !== 4'b0001) begin errors++; $display("FAIL mid_wait_cs: got %b required 0001", ext_cs); end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (ext_cs !== 4'b0000 || ext_we !== 4'b0000) begin
         errors++; $display("FAIL mid_reset_cs: got cs=%b we=%b required 0000", ext_cs, ext_we);
      end
      checks++;
      if (status !== STAT_READY) begin errors++; $display("FAIL mid_reset_status: got %0d required %0d", status, STAT_READY); end
      @(negedge clk);
      reset   = 1'b0;
      command = CMD_IDLE;
      repeat (2) @(negedge clk);
      issue(CMD_READ, 32'h00000000, 32'd0, STAT_READY, 32'h6170692d, "name0_after_reset");
      while (exp_status_q.size() > 0) begin
         logic [1:0] es, os; logic [31:0] ed, od; string nm;
         es = exp_status_q.pop_front(); ed = exp_data_q.pop_front();
         os = obs_status_q.pop_front(); od = obs_data_q.pop_front(); nm = name_q.pop_front();
         checks++;
         if (os !== es) begin errors++; $display("FAIL %s status: got %0d required %0d", nm, os, es); end
         checks++;
         if (od !== ed) begin errors++; $display("FAIL %s data: got %h required %h", nm, od, ed); end
      end
   endtask

   initial begin
      reset         = 1'b1;
      command       = CMD_IDLE;
      address       = '0;
      write_data    = '0;
      ext_ready     = 4'b1111;
      ext_read_data = {32'hfeedface, 32'h12345678, 32'h11111111, 32'h00001000};

      test_reset();
      test_internal_bank();
      test_ext_write();
      test_ext_read();
      test_errors();
      test_timeout();
      test_reset_mid_access();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
